// File: rtl/click_pkg.sv
// Shared types and helpers for the click classifier.
package click_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  // Smallest timer width that holds WINDOW_CYCLES-1 (window is at least 2).
  function automatic int timer_width(input int window_cycles);
    return (window_cycles < 2) ? 1 : $clog2(window_cycles);
  endfunction

endpackage

// File: rtl/click_classifier_edge_strobe.sv
// Rising-edge strobe on a level already synchronous to clk.
// The previous-level reset value is a parameter, so a level that is already high at reset release is ignored.
module edge_strobe #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_rise
);

  logic r_prev;

  // Previous-level register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= RST_VAL;
    end else begin
      r_prev <= i_level;
    end
  end

  assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/click_classifier.sv
// Groups debounced presses into click events (1..MAX_CLICKS) delivered over valid/ready.
// Optional sticky Overflow port for groups dropped under backpressure: CLICK_CLASSIFIER_OVF_EN.
module click_classifier
  import click_pkg::*;
#(
  parameter int WINDOW_CYCLES = 5_000_000,
  parameter int MAX_CLICKS    = 3,
  parameter int CNT_W         = $clog2(MAX_CLICKS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Input,
  output logic             ClickValid,
  output logic [CNT_W-1:0] ClickCount,
  input  logic             ClickReady
`ifdef CLICK_CLASSIFIER_OVF_EN
  ,
  output logic             Overflow
`endif
);

  localparam int               TW         = timer_width(WINDOW_CYCLES);
  localparam logic [TW-1:0]    TIMER_LOAD = TW'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_CLICKS);

  logic             w_press;
  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [TW-1:0]    r_timer;
  logic [TW-1:0]    w_timer_next;
  logic             w_close;
  logic             w_slot_free;
  logic             r_valid;
  logic [CNT_W-1:0] r_count;

  edge_strobe #(
    .RST_VAL (1'b1)
  ) u_edge (
    .clk     (clk),
    .rst     (rst),
    .i_level (Input),
    .o_rise  (w_press)
  );

  // Group FSM state, press counter and gap timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_timer <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_timer <= w_timer_next;
    end
  end

  // Next-state logic; a press on the last window cycle extends the group.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_timer_next = r_timer;
    w_close      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_press) begin
          w_state_next = COUNT;
          w_cnt_next   = CNT_W'(1);
          w_timer_next = TIMER_LOAD;
        end else begin
          w_state_next = IDLE;
        end
      end
      COUNT: begin
        if (w_press) begin
          w_cnt_next   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
          w_timer_next = TIMER_LOAD;
        end else if (r_timer != '0) begin
          w_timer_next = r_timer - TW'(1);
        end else begin
          w_close      = 1'b1;
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
        w_timer_next = '0;
      end
    endcase
  end

  assign w_slot_free = ~r_valid | ClickReady;

  // Output slot; a closing group may reload it in the same cycle as a handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_count <= '0;
    end else if (w_close && w_slot_free) begin
      r_valid <= 1'b1;
      r_count <= r_cnt;
    end else if (ClickReady) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign ClickValid = r_valid;
  assign ClickCount = r_count;

`ifdef CLICK_CLASSIFIER_OVF_EN
  logic r_overflow;

  // Sticky drop indicator, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_close && !w_slot_free) begin
      r_overflow <= 1'b1;
    end else begin
      r_overflow <= r_overflow;
    end
  end

  assign Overflow = r_overflow;
`endif

endmodule

// File: tb/tb_click_classifier.sv
// Scoreboard bench for click_classifier (WINDOW_CYCLES=20, MAX_CLICKS=3).
module tb_click_classifier;

  localparam int W  = 20;
  localparam int M  = 3;
  localparam int CW = $clog2(M + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_s = 1'b0;
  logic          rdy = 1'b1;
  logic          vld;
  logic [CW-1:0] cnt;
`ifdef CLICK_CLASSIFIER_OVF_EN
  logic          ovf;
`endif

  click_classifier #(
    .WINDOW_CYCLES (W),
    .MAX_CLICKS    (M)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .Input      (in_s),
    .ClickValid (vld),
    .ClickCount (cnt),
    .ClickReady (rdy)
`ifdef CLICK_CLASSIFIER_OVF_EN
    ,
    .Overflow   (ovf)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int count;
    int at;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic prev_valid = 1'b0;
  logic prev_hs    = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compares each presented event against the head of the scoreboard.
  always @(negedge clk) begin
    if (vld) begin
      if (q.size() == 0) begin
        check("unexpected_event", int'(vld), 0);
      end else begin
        if (!prev_valid || prev_hs) check("event_cycle", cyc, q[0].at);
        check("event_count", int'(cnt), q[0].count);
        if (rdy) void'(q.pop_front());
      end
    end
    prev_valid <= vld;
    prev_hs    <= vld && rdy;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int n);
    in_s = 1'b1;
    tick(n);
    in_s = 1'b0;
  endtask

  task automatic drained(input string name);
    check(name, q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, int'(vld), 0);
    check({tag, "_count"}, int'(cnt), 0);
`ifdef CLICK_CLASSIFIER_OVF_EN
    check({tag, "_overflow"}, int'(ovf), 0);
`endif
  endtask

  initial begin
    int p;
    // Input already high across reset release must not count as a press.
    in_s = 1'b1;
    tick(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick(5);
    in_s = 1'b0;
    tick(40);
    drained("held_high_no_event");

    // Single press.
    p = cyc;
    q.push_back('{1, p + 1 + W});
    pulse(5);
    tick(100);
    drained("single");

    // Double press, second 15 cycles after the first.
    p = cyc;
    q.push_back('{2, p + 15 + 1 + W});
    pulse(3);
    tick(12);
    pulse(3);
    tick(60);
    drained("double");

    // Five presses 10 cycles apart saturate at MAX_CLICKS.
    p = cyc;
    q.push_back('{3, p + 40 + 1 + W});
    repeat (5) begin
      pulse(2);
      tick(8);
    end
    tick(50);
    drained("saturate");

    // Second press registered exactly when the timer is zero extends the group.
    p = cyc;
    q.push_back('{2, p + 20 + 1 + W});
    pulse(1);
    tick(19);
    pulse(1);
    tick(50);
    drained("window_extend");

    // One cycle later the first group has already closed.
    p = cyc;
    q.push_back('{1, p + 1 + W});
    q.push_back('{1, p + 21 + 1 + W});
    pulse(1);
    tick(20);
    pulse(1);
    tick(50);
    drained("window_split");

    // Backpressure: first event held, second group dropped.
    rdy = 1'b0;
    p = cyc;
    q.push_back('{1, p + 1 + W});
    pulse(1);
    tick(29);
    pulse(1);
    tick(9);
    pulse(1);
    tick(40);
    check("bp_held_valid", int'(vld), 1);
    check("bp_held_count", int'(cnt), 1);
`ifdef CLICK_CLASSIFIER_OVF_EN
    check("bp_overflow", int'(ovf), 1);
`endif
    rdy = 1'b1;
    tick(1);
    check("bp_valid_after_handshake", int'(vld), 0);
    tick(5);
    drained("backpressure");

    // Reset in the middle of a two-press group.
    pulse(2);
    tick(8);
    pulse(2);
    tick(3);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_midgroup");
    tick(2);
    rst = 1'b0;
    tick(60);
    drained("rst_midgroup_no_event");

    // Reset with an event pending in the slot.
    rdy = 1'b0;
    p = cyc;
    q.push_back('{1, p + 1 + W});
    pulse(1);
    tick(25);
    check("pending_before_reset", int'(vld), 1);
    rst = 1'b1;
    q.delete();
    #1;
    check_reset_outputs("rst_pending");
    tick(2);
    rst = 1'b0;
    rdy = 1'b1;
    tick(60);
    drained("rst_pending_no_event");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
